// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Two-digit multiplexed 7-segment driver. Takes the BCD
//                ones/tens digits, snapshots them once per frame and scans
//                them onto a shared active-high segment bus with one-hot
//                digit enables. A blanking gap at the start of every digit
//                slot (all digits off) suppresses ghosting.
//                Optional feature macro: SEG_LEADING_ZERO_BLANK_EN
//                (blank the tens digit when it holds zero).
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int SCAN_DIV     = 10000,  // cycles per digit slot (blank + lit), >= 4
    parameter int BLANK_CYCLES = 100     // blank cycles at the start of a slot, 0..SCAN_DIV-1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    output logic [6:0] seg,
    output logic [1:0] digit_en,
    output logic       frame_done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int LIT_CYCLES = SCAN_DIV - BLANK_CYCLES;

    // Last in-state count value for blank and lit states. The blank value is
    // meaningless (and unused) when there is no blanking gap.
    localparam logic [CNT_W-1:0] C_BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] C_LIT_LAST   = CNT_W'(LIT_CYCLES - 1);

    typedef enum logic [1:0] {
        BLANK_ONES = 2'd0,
        LIT_ONES   = 2'd1,
        BLANK_TENS = 2'd2,
        LIT_TENS   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------

    // First state of a frame: the ones blanking gap, or the lit ones slot
    // directly when blanking is disabled.
    function automatic state_t frame_first_state();
        if (BLANK_CYCLES > 0) begin
            return BLANK_ONES;
        end
        return LIT_ONES;
    endfunction

    // Scan order; blank states are skipped entirely when the gap is zero.
    function automatic state_t scan_next(input state_t s);
        state_t n;
        n = s;
        case (s)
            BLANK_ONES: n = LIT_ONES;
            LIT_ONES:   n = (BLANK_CYCLES > 0) ? BLANK_TENS : LIT_TENS;
            BLANK_TENS: n = LIT_TENS;
            LIT_TENS:   n = (BLANK_CYCLES > 0) ? BLANK_ONES : LIT_ONES;
            default:    n = frame_first_state();
        endcase
        return n;
    endfunction

    // BCD to {g,f,e,d,c,b,a}; non-decimal codes show a centre dash.
    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t             state_q,      state_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic               started_q,    started_d;
    logic [3:0]         ones_s_q,     ones_s_d;
    logic [3:0]         tens_s_q,     tens_s_d;
    logic [6:0]         seg_q,        seg_d;
    logic [1:0]         digit_en_q,   digit_en_d;
    logic               frame_done_q, frame_done_d;

    logic [CNT_W-1:0]   slot_last;
    logic               frame_start;

    // Next-state and in-state counter. The reset state is a holding state:
    // the first edge after reset enters cycle 0 of a fresh frame, so that the
    // digits present when reset releases are the ones captured.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        started_d = 1'b1;
        slot_last = ((state_q == BLANK_ONES) || (state_q == BLANK_TENS)) ? C_BLANK_LAST : C_LIT_LAST;

        if (!started_q) begin
            state_d = frame_first_state();
            cnt_d   = '0;
        end else if (cnt_q == slot_last) begin
            state_d = scan_next(state_q);
            cnt_d   = '0;
        end

        // cnt_d is only zero on entry into a state, so this marks exactly the
        // edge that begins a new frame.
        frame_start = (state_d == frame_first_state()) && (cnt_d == '0);
    end

    // Per-frame digit snapshot, taken on the edge that starts the frame so a
    // frame never mixes old and new digit values.
    always_comb begin
        ones_s_d = ones_s_q;
        tens_s_d = tens_s_q;
        if (frame_start) begin
            ones_s_d = ones;
            tens_s_d = tens;
        end
    end

    // Output decode from the upcoming state and snapshot, so the registered
    // outputs change on the same edge as the state. Only one case arm can
    // set an enable bit, which keeps digit_en one-hot or zero at all times.
    always_comb begin
        seg_d        = 7'h00;
        digit_en_d   = 2'b00;
        frame_done_d = (state_d == LIT_TENS) && (cnt_d == C_LIT_LAST);

        case (state_d)
            LIT_ONES: begin
                digit_en_d = 2'b01;
                seg_d      = enc(ones_s_d);
            end
            LIT_TENS: begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
                // A zero tens digit stays dark; the slot timing is unchanged.
                if (tens_s_d != 4'd0) begin
                    digit_en_d = 2'b10;
                    seg_d      = enc(tens_s_d);
                end
`else
                digit_en_d = 2'b10;
                seg_d      = enc(tens_s_d);
`endif
            end
            default: begin
                seg_d      = 7'h00;
                digit_en_d = 2'b00;
            end
        endcase
    end

    // State, snapshot and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= BLANK_ONES;
            cnt_q        <= '0;
            started_q    <= 1'b0;
            ones_s_q     <= 4'd0;
            tens_s_q     <= 4'd0;
            seg_q        <= 7'h00;
            digit_en_q   <= 2'b00;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            started_q    <= started_d;
            ones_s_q     <= ones_s_d;
            tens_s_q     <= tens_s_d;
            seg_q        <= seg_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign digit_en   = digit_en_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Self-checking bench for seg7_scan_driver with SCAN_DIV=8,
//                BLANK_CYCLES=2. Cycle k of a frame is observed just after
//                the k-th rising edge counted from the first edge with reset
//                low. Honours SEG_LEADING_ZERO_BLANK_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int SCAN  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 2 * SCAN;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] ones  = 4'd0;
    logic [3:0] tens  = 4'd0;
    logic [6:0] seg;
    logic [1:0] digit_en;
    logic       frame_done;

    seg7_scan_driver #(
        .SCAN_DIV     (SCAN),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ones       (ones),
        .tens       (tens),
        .seg        (seg),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [6:0] seg;
        logic [1:0] en;
        logic       fd;
    } exp_t;

    exp_t       sb[$];
    int         compared   = 0;
    int         mismatched = 0;
    int         pos        = 0;     // frame position of the next edge
    logic [3:0] snap_o     = 4'd0;
    logic [3:0] snap_t     = 4'd0;

    // Reference segment table for digits 0..9; anything else is a dash.
    function automatic logic [6:0] ref_enc(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (d < 4'd10) return tbl[d];
        return 7'h40;
    endfunction

    // Predict the outputs after the next edge, queue them, clock once and
    // compare against what the DUT shows.
    task automatic tick(input string tag);
        exp_t e;
        exp_t got;
        int   slot;
        int   off;
        e = '0;
        if (reset) begin
            pos = 0;
        end else begin
            if (pos == 0) begin
                snap_o = ones;
                snap_t = tens;
            end
            slot = pos / SCAN;
            off  = pos % SCAN;
            if (off >= BLANK) begin
                if (slot == 0) begin
                    e.en  = 2'b01;
                    e.seg = ref_enc(snap_o);
                end else begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
                    if (snap_t != 4'd0) begin
                        e.en  = 2'b10;
                        e.seg = ref_enc(snap_t);
                    end
`else
                    e.en  = 2'b10;
                    e.seg = ref_enc(snap_t);
`endif
                end
            end
            e.fd = (pos == FRAME - 1);
            pos  = (pos + 1) % FRAME;
        end
        sb.push_back(e);

        @(posedge clock);
        #1;
        got = sb.pop_front();

        compared++;
        assert (seg === got.seg) else begin
            mismatched++;
            $error("FAIL %s seg pos=%0d observed=%h expected=%h", tag, pos, seg, got.seg);
        end
        compared++;
        assert (digit_en === got.en) else begin
            mismatched++;
            $error("FAIL %s digit_en pos=%0d observed=%b expected=%b", tag, pos, digit_en, got.en);
        end
        compared++;
        assert (frame_done === got.fd) else begin
            mismatched++;
            $error("FAIL %s frame_done pos=%0d observed=%b expected=%b", tag, pos, frame_done, got.fd);
        end
    endtask

    initial begin
        // Reset held for three edges: everything dark.
        reset = 1'b1;
        ones  = 4'd7;
        tens  = 4'd4;
        repeat (3) tick("reset_hold");

        // Frame 1 shows 7/4; ones changes to 3 at cycle 5 with no visible effect.
        reset = 1'b0;
        repeat (5) tick("frame_74");
        ones = 4'd3;
        repeat (11) tick("frame_74_late_change");

        // Frame 2 picks up the new ones digit.
        repeat (16) tick("frame_34");

        // Invalid codes on both digits show dashes.
        ones = 4'd12;
        tens = 4'd15;
        repeat (16) tick("frame_dash");

        // Zero tens digit (leading-zero behaviour depends on the build).
        ones = 4'd5;
        tens = 4'd0;
        repeat (16) tick("frame_tens_zero");

        // Reset pulsed during the tens lit slot at cycle 12.
        ones = 4'd9;
        tens = 4'd8;
        repeat (12) tick("frame_98");
        reset = 1'b1;
        tick("reset_mid_frame");
        reset = 1'b0;

        // Restart timing; a tens change mid-frame only lands next frame.
        ones = 4'd1;
        tens = 4'd2;
        repeat (10) tick("restart_12");
        tens = 4'd6;
        repeat (6) tick("restart_12_late_change");
        repeat (16) tick("frame_16");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
